// File: rtl/vend_change_ctrl.sv
// vend_change_ctrl -- coin-operated vending controller with change return.
//
// Collects coins (1/2/5/10) until the credit covers the latched price,
// requests a vend, then pays any remaining credit back through the change
// hopper using the largest denomination that fits.  A cancel while
// collecting refunds the whole credit through the same change path.
//
// Ports
//   clk          system clock, rising edge
//   reset_n      synchronous active-low reset
//   one/two/five/ten  one-cycle coin-accept pulses
//   cancel       refund request (level-sampled, COLLECT only)
//   price[4:0]   item price, sampled while IDLE
//   vend_ack     dispenser released the item (honoured in VEND only)
//   hopper_rdy   change hopper accepts a coin command this cycle
//   credit[5:0]  current credit register
//   busy         high in COLLECT, VEND, CHANGE
//   vend_req     dispense request, held through VEND
//   vended       one-cycle pulse the cycle after vend_ack is taken
//   ret_valid    one-cycle coin-return command
//   ret_coin[1:0] return denomination: 00=1, 01=2, 10=5, 11=10
//   coin_reject  one-cycle pulse, a coin was seen but not credited
//   dbg_state[1:0] FSM state: 0=IDLE 1=COLLECT 2=VEND 3=CHANGE
//
// Change handshake: a coin is handed to the hopper in any cycle where
// ret_valid is high.  ret_valid is only raised when hopper_rdy is high,
// so every ret_valid cycle is a completed transfer and the credit is
// reduced by that coin on the same clock edge.
module vend_change_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       one,
    input  logic       two,
    input  logic       five,
    input  logic       ten,
    input  logic       cancel,
    input  logic [4:0] price,
    input  logic       vend_ack,
    input  logic       hopper_rdy,
    output logic [5:0] credit,
    output logic       busy,
    output logic       vend_req,
    output logic       vended,
    output logic       ret_valid,
    output logic [1:0] ret_coin,
    output logic       coin_reject,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_t;

    state_t     state, state_next;
    logic [5:0] credit_next;
    logic [4:0] price_q, price_next;
    logic       vended_next, reject_next;

    // Coin decode: only the highest asserted coin counts; coin_extra flags
    // any lower coin arriving in the same cycle.
    logic       coin_any, coin_extra;
    logic [5:0] coin_val;
    // Largest return denomination not exceeding the current credit.
    logic [1:0] chg_code;
    logic [5:0] chg_amt;

    always_comb begin
        coin_any   = ten | five | two | one;
        coin_extra = (ten & (five | two | one)) | (five & (two | one)) | (two & one);
        if (ten)       coin_val = 6'd10;
        else if (five) coin_val = 6'd5;
        else if (two)  coin_val = 6'd2;
        else if (one)  coin_val = 6'd1;
        else           coin_val = 6'd0;
    end

    always_comb begin
        if (credit >= 6'd10)     begin chg_code = 2'b11; chg_amt = 6'd10; end
        else if (credit >= 6'd5) begin chg_code = 2'b10; chg_amt = 6'd5;  end
        else if (credit >= 6'd2) begin chg_code = 2'b01; chg_amt = 6'd2;  end
        else                     begin chg_code = 2'b00; chg_amt = 6'd1;  end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            credit      <= 6'd0;
            price_q     <= 5'd0;
            vended      <= 1'b0;
            coin_reject <= 1'b0;
        end else begin
            state       <= state_next;
            credit      <= credit_next;
            price_q     <= price_next;
            vended      <= vended_next;
            coin_reject <= reject_next;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_next  = state;
        credit_next = credit;
        price_next  = price_q;
        vended_next = 1'b0;
        reject_next = 1'b0;
        case (state)
            IDLE: begin
                price_next = price;
                if (coin_any) begin
                    if (price == 5'd0) begin
                        reject_next = 1'b1;
                    end else begin
                        credit_next = coin_val;
                        reject_next = coin_extra;
                        state_next  = COLLECT;
                    end
                end
            end
            COLLECT: begin
                // Price check uses the registered credit, so a coin in the
                // same cycle as a covered price is not credited.
                if (credit >= {1'b0, price_q}) begin
                    credit_next = credit - {1'b0, price_q};
                    reject_next = coin_any;
                    state_next  = VEND;
                end else if (cancel) begin
                    reject_next = coin_any;
                    state_next  = CHANGE;
                end else if (coin_any) begin
                    credit_next = credit + coin_val;
                    reject_next = coin_extra;
                end
            end
            VEND: begin
                reject_next = coin_any;
                if (vend_ack) begin
                    vended_next = 1'b1;
                    state_next  = (credit != 6'd0) ? CHANGE : IDLE;
                end
            end
            CHANGE: begin
                reject_next = coin_any;
                if (credit == 6'd0)
                    state_next = IDLE;
                else if (hopper_rdy)
                    credit_next = credit - chg_amt;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs derived from state (and hopper_rdy for the change command).
    always_comb begin
        busy      = (state != IDLE);
        vend_req  = (state == VEND);
        ret_valid = (state == CHANGE) && hopper_rdy && (credit != 6'd0);
        ret_coin  = ret_valid ? chg_code : 2'b00;
        dbg_state = state;
    end

endmodule

// File: doc/vend_change_ctrl.md
VEND_CHANGE_CTRL -- requirements
Module: vend_change_ctrl

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 reset_n  in  1  synchronous, active-low reset.
REQ-003 one, two, five, ten  in  1 each  coin-accept pulses, one cycle per coin, values 1/2/5/10.
REQ-004 cancel  in  1  customer refund request, level-sampled.
REQ-005 price  in  5  item price 1..31; sampled only in IDLE.
REQ-006 vend_ack  in  1  dispenser mechanism has released the item.
REQ-007 hopper_rdy  in  1  change hopper can take a coin command this cycle.
REQ-008 credit  out  6  current credit register, unsigned.
REQ-009 busy  out  1  high in COLLECT, VEND and CHANGE.
REQ-010 vend_req  out  1  item dispense request, held until acknowledged.
REQ-011 vended  out  1  one-cycle pulse, cycle after vend_ack accepted.
REQ-012 ret_valid  out  1  one-cycle coin-return command.
REQ-013 ret_coin  out  2  return denomination when ret_valid: 00=1, 01=2, 10=5, 11=10.
REQ-014 coin_reject  out  1  one-cycle pulse: coin seen but not credited.

Function
REQ-015 States SHALL be IDLE, COLLECT, VEND, CHANGE; 2-bit encoding, registered.
REQ-016 Coin priority SHALL be ten > five > two > one; only the highest coin asserted in a cycle is credited; any lower coin asserted in the same cycle SHALL pulse coin_reject next cycle.
REQ-017 Credited coin SHALL appear in credit one cycle after the pulse (6-bit add, no overflow possible: max credit is 30+10=40).
REQ-018 IDLE: price_q <= price every cycle; price==0 SHALL reject all coins (coin_reject) and stay IDLE; otherwise a coin loads credit and moves to COLLECT.
REQ-019 COLLECT, priority order evaluated on registered credit: (a) credit >= price_q -> VEND, credit <= credit - price_q, any coin that cycle rejected; (b) else cancel -> CHANGE (refund), coin that cycle rejected; (c) else coin -> credit += value.
REQ-020 VEND: vend_req=1; coins rejected; cancel ignored; on vend_ack -> CHANGE if credit != 0 else IDLE; vended pulses the following cycle.
REQ-021 CHANGE: each cycle with hopper_rdy=1 and credit != 0, emit ret_valid with largest denomination <= credit and subtract it; hopper_rdy=0 stalls with no output; credit==0 -> IDLE next cycle.
REQ-022 CHANGE SHALL reject all coins and ignore cancel.
REQ-023 ret_valid, vended, coin_reject SHALL never be high for more than one consecutive cycle per event; ret_valid and vend_req SHALL never be high simultaneously.
REQ-024 busy SHALL be combinationally derived from state only.
REQ-025 A vend_ack outside VEND SHALL be ignored.

Reset
REQ-026 reset_n=0 at a clock edge SHALL force IDLE, credit=0, price_q=0, all outputs 0, regardless of state (including mid-VEND or mid-CHANGE; pending credit is discarded, no refund).
REQ-027 First coin SHALL be accepted on the first cycle after reset_n returns high.

Verification
REQ-028 price=15; ten, then five -> credit 10, 15; next cycle VEND, vend_req=1; vend_ack -> vended pulse, IDLE, no ret_valid.
REQ-029 price=15; ten, ten -> credit 20 -> VEND with credit 5; ack -> single ret_valid ret_coin=10 -> IDLE, credit 0.
REQ-030 price=12; ten, five -> credit 15 -> VEND credit 3; ack -> ret_coin 01 then 00 on consecutive cycles -> IDLE.
REQ-031 price=20; two, one, cancel -> no vend_req; ret_coin 01 then 00; hopper_rdy held 0 for 3 cycles mid-refund -> outputs stall, credit holds 1, then resumes.
REQ-032 five+ten same cycle -> credit 10, coin_reject pulse; coin during VEND -> coin_reject, credit unchanged.
REQ-033 reset_n=0 during CHANGE with credit 7 -> next cycle IDLE, credit 0, ret_valid 0, busy 0.
